playlist_ctrl: RTL



---
 rtl/playlist_ctrl.sv | 118 +++++++++++
 1 files changed

// File: rtl/playlist_ctrl.sv
// playlist_ctrl: song-select / play-level sequencer between the button
// one-pulsers and the song reader. A song change always passes through a
// one-cycle SWITCH (player reset) and a one-cycle SETTLE (ROM read latency)
// before landing in PLAY or PAUSED according to the resume flag.
module playlist_ctrl #(
   parameter int SONG_BITS    = 2,
   parameter int NUM_SONGS    = 4,
   parameter int AUTO_ADVANCE = 1,
   parameter int LOOP_ALL     = 0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 play_button,
   input  logic                 next_button,
   input  logic                 prev_button,
   input  logic                 song_done,
   output logic [SONG_BITS-1:0] song,
   output logic                 play,
   output logic                 reset_player,
   output logic                 playing,
   output logic                 playlist_done
);

   typedef enum logic [1:0] {S_PAUSED, S_PLAY, S_SWITCH, S_SETTLE} state_t;

   localparam logic [SONG_BITS-1:0] LAST = SONG_BITS'(NUM_SONGS - 1);

   state_t                r_state;
   logic [SONG_BITS-1:0]  r_song;
   logic                  r_resume;
   logic                  r_play;
   logic                  r_reset_player;
   logic                  r_playlist_done;

   logic [SONG_BITS-1:0]  w_song_inc;
   logic [SONG_BITS-1:0]  w_song_dec;
   logic                  w_adv_ok;

   // Neighbouring song indices with wrap at NUM_SONGS, and whether a finished
   // song should roll into the next one.
   always_comb begin
      w_song_inc = (r_song == LAST) ? '0 : r_song + 1'b1;
      w_song_dec = (r_song == '0) ? LAST : r_song - 1'b1;
      w_adv_ok   = (AUTO_ADVANCE != 0) && ((r_song != LAST) || (LOOP_ALL != 0));
   end

   // Sequencer FSM; play/reset_player/playlist_done are registered alongside
   // the state so they are glitch-free decodes of the state being entered.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state         <= S_PAUSED;
         r_song          <= '0;
         r_resume        <= 1'b0;
         r_play          <= 1'b0;
         r_reset_player  <= 1'b0;
         r_playlist_done <= 1'b0;
      end else begin
         r_reset_player  <= 1'b0;
         r_playlist_done <= 1'b0;
         case (r_state)
            S_PAUSED, S_PLAY: begin
               if (next_button) begin
                  r_song         <= w_song_inc;
                  r_resume       <= 1'b0;
                  r_state        <= S_SWITCH;
                  r_reset_player <= 1'b1;
                  r_play         <= 1'b0;
               end else if (prev_button) begin
                  r_song         <= w_song_dec;
                  r_resume       <= 1'b0;
                  r_state        <= S_SWITCH;
                  r_reset_player <= 1'b1;
                  r_play         <= 1'b0;
               end else if (song_done && (r_state == S_PLAY)) begin
                  // song_done is not an event while paused, so a play press in
                  // that same cycle still takes effect below.
                  r_state        <= S_SWITCH;
                  r_reset_player <= 1'b1;
                  r_play         <= 1'b0;
                  if (w_adv_ok) begin
                     r_song   <= w_song_inc;
                     r_resume <= 1'b1;
                  end else begin
                     r_resume        <= 1'b0;
                     r_playlist_done <= 1'b1;
                  end
               end else if (play_button) begin
                  if (r_state == S_PAUSED) begin
                     r_state <= S_PLAY;
                     r_play  <= 1'b1;
                  end else begin
                     r_state <= S_PAUSED;
                     r_play  <= 1'b0;
                  end
               end
            end
            S_SWITCH: begin
               r_state <= S_SETTLE;
            end
            S_SETTLE: begin
               r_state <= r_resume ? S_PLAY : S_PAUSED;
               r_play  <= r_resume;
            end
            default: begin
               r_state <= S_PAUSED;
               r_play  <= 1'b0;
            end
         endcase
      end
   end

   assign song          = r_song;
   assign play          = r_play;
   assign playing       = r_play;
   assign reset_player  = r_reset_player;
   assign playlist_done = r_playlist_done;

endmodule
